riscv_divider: RTL

- Iterative radix-2 restoring integer divider for the RV64M execute stage; the inverse-operation companion of the Booth multiplier.
- Implements DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW.
- Sits beside the multiplier in the execute unit. The pipeline stalls while it is busy and releases on its one-cycle valid pulse.

---
 rtl/riscv_divider.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/riscv_divider.sv
// Iterative radix-2 restoring divider for RV64M (DIV/DIVU/REM/REMU and W forms).
// It retires one quotient bit per cycle. Divide-by-zero and signed overflow take a two-cycle fast path.
module riscv_divider #(
    parameter int XLEN = 64
) (
    input  logic            i_riscv_div_clk,
    input  logic            i_riscv_div_rst,
    input  logic [XLEN-1:0] i_riscv_div_rs1data,
    input  logic [XLEN-1:0] i_riscv_div_rs2data,
    input  logic [3:0]      i_riscv_div_divctrl,
    input  logic            i_riscv_div_flush,
    output logic [XLEN-1:0] o_riscv_div_result,
    output logic            o_riscv_div_valid,
    output logic            o_riscv_div_busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0]        r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvs;
    logic [6:0]        r_count;
    logic [XLEN-1:0]   r_result;
    logic              r_valid;

    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] x);
        return (~x) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [XLEN-1:0] f_sext32(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

    logic                   w_is_w;
    logic                   w_uns;
    logic                   w_start;
    logic signed [XLEN-1:0] w_a_ext;
    logic signed [XLEN-1:0] w_b_ext;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [XLEN-1:0]        w_a_mag;
    logic [XLEN-1:0]        w_b_mag;
    logic                   w_div_zero;
    logic                   w_ovf;
    logic                   w_special;

    assign w_is_w  = i_riscv_div_divctrl[2];
    assign w_uns   = i_riscv_div_divctrl[0];
    assign w_start = i_riscv_div_divctrl[3] & ~r_valid & ~i_riscv_div_flush & (r_state == S_IDLE);

    always_comb begin
        w_a_ext = i_riscv_div_rs1data;
        w_b_ext = i_riscv_div_rs2data;
        if (w_is_w) begin
            w_a_ext = w_uns ? {32'b0, i_riscv_div_rs1data[31:0]} : f_sext32(i_riscv_div_rs1data[31:0]);
            w_b_ext = w_uns ? {32'b0, i_riscv_div_rs2data[31:0]} : f_sext32(i_riscv_div_rs2data[31:0]);
        end
    end

    assign w_a_neg    = ~w_uns & (w_a_ext < 0);
    assign w_b_neg    = ~w_uns & (w_b_ext < 0);
    assign w_a_mag    = w_a_neg ? f_neg(w_a_ext) : w_a_ext;
    assign w_b_mag    = w_b_neg ? f_neg(w_b_ext) : w_b_ext;
    assign w_div_zero = (w_b_ext == '0);
    assign w_ovf      = ~w_uns & (w_is_w
                        ? (i_riscv_div_rs1data[31:0] == 32'h8000_0000) && (i_riscv_div_rs2data[31:0] == 32'hFFFF_FFFF)
                        : (i_riscv_div_rs1data == {1'b1, {(XLEN-1){1'b0}}}) && (i_riscv_div_rs2data == '1));
    assign w_special  = w_div_zero | w_ovf;

    // Restoring step: shift {rem,quo}, trial-subtract in 65 bits, keep or restore.
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_fits;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic            w_last;

    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_fits    = ~w_diff[XLEN];
    assign w_rem_nxt = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_fits};
    assign w_last    = (r_count == (r_op[2] ? 7'd31 : 7'd63));

    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_sel;
    logic [XLEN-1:0] w_final;

    assign w_q_fix = r_neg_q ? f_neg(r_quo) : r_quo;
    assign w_r_fix = r_neg_r ? f_neg(r_rem) : r_rem;
    assign w_sel   = r_op[1] ? w_r_fix : w_q_fix;
    assign w_final = r_op[2] ? f_sext32(w_sel[31:0]) : w_sel;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_next = w_special ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (i_riscv_div_flush)
                    w_state_next = S_IDLE;
                else if (w_last)
                    w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_div_clk) begin
        if (i_riscv_div_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge i_riscv_div_clk) begin
        if (i_riscv_div_rst) begin
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op    <= i_riscv_div_divctrl[2:0];
                        r_count <= '0;
                        r_dvs   <= w_b_mag;
                        if (w_special) begin
                            // Final values are loaded directly; no sign fix-up applies.
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_quo   <= w_div_zero ? '1 : i_riscv_div_rs1data;
                            r_rem   <= w_div_zero ? i_riscv_div_rs1data : '0;
                        end else begin
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_rem   <= '0;
                            r_quo   <= w_is_w ? {w_a_mag[31:0], 32'b0} : w_a_mag;
                        end
                    end
                end
                S_BUSY: begin
                    if (!i_riscv_div_flush) begin
                        r_rem   <= w_rem_nxt;
                        r_quo   <= w_quo_nxt;
                        r_count <= r_count + 7'd1;
                    end
                end
                S_DONE: begin
                    if (!i_riscv_div_flush) begin
                        r_result <= w_final;
                        r_valid  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_riscv_div_result = r_result;
    assign o_riscv_div_valid  = r_valid;
    // Busy also covers the strobe cycle so the stall drops together with valid.
    assign o_riscv_div_busy   = (r_state != S_IDLE) | r_valid;

endmodule
